// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and depth helper for the 2R1W scoreboarded register file
package regfile_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits with reserve-over-clear priority and source hazard lookups
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rsv_i,
  input  logic [ADDR_WIDTH-1:0]         rsv_addr_i,
  input  logic                          wr_i,
  input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
  input  logic [ADDR_WIDTH-1:0]         rd1_addr_i,
  input  logic [ADDR_WIDTH-1:0]         rd2_addr_i,
  output logic [depth(ADDR_WIDTH)-1:0]  pending_o,
  output logic                          busy1_o,
  output logic                          busy2_o
);
  localparam int DEPTH = depth(ADDR_WIDTH);
  logic [DEPTH-1:0] pend_q, pend_d;
  always_comb begin
    pend_d = pend_q;
    if (wr_i) pend_d[wr_addr_i] = 1'b0;
    // a fresh reservation outranks the completing write: a new producer was issued
    if (rsv_i) pend_d[rsv_addr_i] = 1'b1;
    if (ZERO_REG) pend_d[0] = 1'b0;
  end
  always_ff @(posedge clk) pend_q <= rst ? '0 : pend_d;
  assign pending_o = pend_q;
  assign busy1_o   = pend_q[rd1_addr_i] & ~(wr_i & (wr_addr_i == rd1_addr_i));
  assign busy2_o   = pend_q[rd2_addr_i] & ~(wr_i & (wr_addr_i == rd2_addr_i));
endmodule

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: 2-read/1-write register file with registered reads, write bypass and hazard scoreboard
module regfile_2r1w_sb import regfile_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RD_REQ,
  input  logic [ADDR_WIDTH-1:0]         ADDR_R1,
  input  logic [ADDR_WIDTH-1:0]         ADDR_R2,
  output logic                          RD_ACK,
  output logic [DATA_WIDTH-1:0]         DATA_R1,
  output logic [DATA_WIDTH-1:0]         DATA_R2,
  output logic                          RD_VALID,
  input  logic                          RSV,
  input  logic [ADDR_WIDTH-1:0]         ADDR_RSV,
  input  logic                          WRITE,
  input  logic [ADDR_WIDTH-1:0]         ADDR_W,
  input  logic [DATA_WIDTH-1:0]         DATA_W,
  output logic [depth(ADDR_WIDTH)-1:0]  PENDING
);
  localparam int DEPTH = depth(ADDR_WIDTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_r1_q, data_r2_q, data_r1_d, data_r2_d;
  logic                  valid_q, busy1, busy2, wr_en;
  regfile_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH), .ZERO_REG(ZERO_REG)) u_sb (
    .clk        (CLK),
    .rst        (RST),
    .rsv_i      (RSV),
    .rsv_addr_i (ADDR_RSV),
    .wr_i       (WRITE),
    .wr_addr_i  (ADDR_W),
    .rd1_addr_i (ADDR_R1),
    .rd2_addr_i (ADDR_R2),
    .pending_o  (PENDING),
    .busy1_o    (busy1),
    .busy2_o    (busy2)
  );
  assign wr_en  = WRITE & ~(ZERO_REG & (ADDR_W == '0));
  assign RD_ACK = RD_REQ & ~RST & ~busy1 & ~busy2;
  // hardwired zero takes precedence over the bypass so r0 never forwards write data
  assign data_r1_d = (ZERO_REG && ADDR_R1 == '0) ? '0 : (WRITE && ADDR_W == ADDR_R1) ? DATA_W : mem_q[ADDR_R1];
  assign data_r2_d = (ZERO_REG && ADDR_R2 == '0) ? '0 : (WRITE && ADDR_W == ADDR_R2) ? DATA_W : mem_q[ADDR_R2];
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_q     <= '{default: '0};
      data_r1_q <= '0;
      data_r2_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (wr_en) mem_q[ADDR_W] <= DATA_W;
      data_r1_q <= RD_ACK ? data_r1_d : data_r1_q;
      data_r2_q <= RD_ACK ? data_r2_d : data_r2_q;
      valid_q   <= RD_ACK;
    end
  end
  assign DATA_R1  = data_r1_q;
  assign DATA_R2  = data_r2_q;
  assign RD_VALID = valid_q;
endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb_regfile_2r1w_sb: directed vector table plus random traffic for ZERO_REG=0/1 instances against a reference model
module tb_regfile_2r1w_sb;
  typedef struct {
    logic rst, req; logic [4:0] a1, a2; logic rsv; logic [4:0] ars;
    logic wr; logic [4:0] aw; logic [31:0] dw;
  } in_t;
  typedef struct {
    in_t i; logic ack; logic [31:0] d1, d2; logic v; logic [31:0] pend;
  } vec_t;

  logic clk = 0, rst = 0, req = 0, rsv = 0, wr = 0;
  logic [4:0] a1 = 0, a2 = 0, ars = 0, aw = 0;
  logic [31:0] dw = 0;
  logic [1:0] ack, vld;
  logic [1:0][31:0] d1, d2, pend;
  logic ack_cap;
  int checks = 0, errors = 0;

  logic [31:0] m_mem [2][32];
  bit          m_pend[2][32];
  logic [31:0] m_d1[2], m_d2[2];
  bit          m_v[2], m_ack[2];

  always #5 clk = ~clk;

  regfile_2r1w_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) dut0 (
    .CLK(clk), .RST(rst), .RD_REQ(req), .ADDR_R1(a1), .ADDR_R2(a2), .RD_ACK(ack[0]),
    .DATA_R1(d1[0]), .DATA_R2(d2[0]), .RD_VALID(vld[0]), .RSV(rsv), .ADDR_RSV(ars),
    .WRITE(wr), .ADDR_W(aw), .DATA_W(dw), .PENDING(pend[0]));
  regfile_2r1w_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut1 (
    .CLK(clk), .RST(rst), .RD_REQ(req), .ADDR_R1(a1), .ADDR_R2(a2), .RD_ACK(ack[1]),
    .DATA_R1(d1[1]), .DATA_R2(d2[1]), .RD_VALID(vld[1]), .RSV(rsv), .ADDR_RSV(ars),
    .WRITE(wr), .ADDR_W(aw), .DATA_W(dw), .PENDING(pend[1]));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic bit m_busy(input int k, input in_t x, input logic [4:0] a);
    return m_pend[k][a] && !(x.wr && x.aw == a);
  endfunction

  function automatic logic [31:0] m_val(input int k, input in_t x, input logic [4:0] a);
    if (k == 1 && a == 0) return 0;
    if (x.wr && x.aw == a) return x.dw;
    return m_mem[k][a];
  endfunction

  task automatic do_cycle(input in_t x);
    logic [31:0] pv;
    @(negedge clk);
    rst = x.rst; req = x.req; a1 = x.a1; a2 = x.a2; rsv = x.rsv; ars = x.ars;
    wr = x.wr; aw = x.aw; dw = x.dw;
    #1;
    ack_cap = ack[1];
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = x.req && !x.rst && !m_busy(k, x, x.a1) && !m_busy(k, x, x.a2);
      chk($sformatf("model_ack%0d", k), {31'b0, ack[k]}, {31'b0, m_ack[k]});
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (x.rst) begin
        for (int r = 0; r < 32; r++) begin m_mem[k][r] = 0; m_pend[k][r] = 0; end
        m_d1[k] = 0; m_d2[k] = 0; m_v[k] = 0;
      end else begin
        if (m_ack[k]) begin m_d1[k] = m_val(k, x, x.a1); m_d2[k] = m_val(k, x, x.a2); end
        m_v[k] = m_ack[k];
        if (x.wr && !(k == 1 && x.aw == 0)) m_mem[k][x.aw] = x.dw;
        if (x.wr) m_pend[k][x.aw] = 0;
        if (x.rsv && !(k == 1 && x.ars == 0)) m_pend[k][x.ars] = 1;
      end
      pv = 0;
      for (int r = 0; r < 32; r++) pv[r] = m_pend[k][r];
      chk($sformatf("model_d1_%0d", k), d1[k], m_d1[k]);
      chk($sformatf("model_d2_%0d", k), d2[k], m_d2[k]);
      chk($sformatf("model_valid%0d", k), {31'b0, vld[k]}, {31'b0, m_v[k]});
      chk($sformatf("model_pending%0d", k), pend[k], pv);
    end
  endtask

  function automatic vec_t row(input logic r, q, input logic [4:0] s1, s2, input logic rv,
                               input logic [4:0] ra, input logic w, input logic [4:0] wa,
                               input logic [31:0] wd, input logic ea, input logic [31:0] e1, e2,
                               input logic ev, input logic [31:0] ep);
    vec_t v;
    v.i = '{rst: r, req: q, a1: s1, a2: s2, rsv: rv, ars: ra, wr: w, aw: wa, dw: wd};
    v.ack = ea; v.d1 = e1; v.d2 = e2; v.v = ev; v.pend = ep;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    in_t x;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) begin m_mem[k][r] = 0; m_pend[k][r] = 0; end
      m_d1[k] = 0; m_d2[k] = 0; m_v[k] = 0;
    end
    //             rst req a1 a2 rsv ars wr aw dw            ack d1            d2            v  pending (ZERO_REG=1 instance)
    tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0,            0,            0, 0));
    tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0,            0,            0, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF,  0, 0,            0,            0, 0));
    tbl.push_back(row(0, 1, 5, 0, 0, 0, 0, 0, 0,             1, 32'hDEADBEEF, 0,            1, 0));
    tbl.push_back(row(0, 1, 7, 7, 0, 0, 1, 7, 32'h12345678,  1, 32'h12345678, 32'h12345678, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 3, 0, 0, 0,             0, 32'h12345678, 32'h12345678, 0, 32'h8));
    tbl.push_back(row(0, 1, 3, 1, 0, 0, 0, 0, 0,             0, 32'h12345678, 32'h12345678, 0, 32'h8));
    tbl.push_back(row(0, 1, 3, 1, 0, 0, 0, 0, 0,             0, 32'h12345678, 32'h12345678, 0, 32'h8));
    tbl.push_back(row(0, 1, 3, 1, 0, 0, 1, 3, 32'hA5A5A5A5,  1, 32'hA5A5A5A5, 0,            1, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 9, 0, 0, 0,             0, 32'hA5A5A5A5, 0,            0, 32'h200));
    tbl.push_back(row(0, 0, 0, 0, 1, 9, 1, 9, 32'h1,         0, 32'hA5A5A5A5, 0,            0, 32'h200));
    tbl.push_back(row(0, 1, 9, 0, 0, 0, 0, 0, 0,             0, 32'hA5A5A5A5, 0,            0, 32'h200));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 9, 32'h1,         0, 32'hA5A5A5A5, 0,            0, 0));
    tbl.push_back(row(0, 1, 9, 9, 0, 0, 0, 0, 0,             1, 32'h1,        32'h1,        1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF,  0, 32'h1,        32'h1,        0, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 0, 0, 0, 0,             0, 32'h1,        32'h1,        0, 0));
    tbl.push_back(row(0, 1, 0, 0, 0, 0, 0, 0, 0,             1, 0,            0,            1, 0));
    tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF,  0, 0,            0,            0, 0));
    tbl.push_back(row(0, 1, 0, 5, 0, 0, 0, 0, 0,             1, 0,            32'hDEADBEEF, 1, 0));
    tbl.push_back(row(0, 0, 0, 0, 1, 2, 0, 0, 0,             0, 0,            32'hDEADBEEF, 0, 32'h4));
    tbl.push_back(row(0, 0, 0, 0, 1, 4, 0, 0, 0,             0, 0,            32'hDEADBEEF, 0, 32'h14));
    tbl.push_back(row(1, 1, 2, 5, 1, 6, 1, 5, 32'h7,         0, 0,            0,            0, 0));
    tbl.push_back(row(0, 1, 2, 5, 0, 0, 0, 0, 0,             1, 0,            0,            1, 0));
    foreach (tbl[n]) begin
      do_cycle(tbl[n].i);
      chk($sformatf("vec%0d_ack", n), {31'b0, ack_cap}, {31'b0, tbl[n].ack});
      chk($sformatf("vec%0d_d1", n), d1[1], tbl[n].d1);
      chk($sformatf("vec%0d_d2", n), d2[1], tbl[n].d2);
      chk($sformatf("vec%0d_valid", n), {31'b0, vld[1]}, {31'b0, tbl[n].v});
      chk($sformatf("vec%0d_pending", n), pend[1], tbl[n].pend);
    end
    for (int c = 0; c < 800; c++) begin
      x.rst = ($urandom_range(0, 79) == 0);
      x.req = ($urandom_range(0, 3) != 0);
      x.a1  = 5'($urandom_range(0, 7));
      x.a2  = 5'($urandom_range(0, 7));
      x.rsv = ($urandom_range(0, 2) == 0);
      x.ars = 5'($urandom_range(0, 7));
      x.wr  = ($urandom_range(0, 1) == 0);
      x.aw  = 5'($urandom_range(0, 7));
      x.dw  = $urandom;
      do_cycle(x);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
